signed_sum_accumulator: RTL
===========================

// Module: signed_sum_accumulator
// PURPOSE
//  Downstream consumer of the registered 5-bit signed adder output. Accumulates a
//  frame of COUNT signed sums into a saturating ACC_WIDTH-bit total and presents it
//  over a valid/ready handshake. Marks any frame whose running total clipped.
//  Sits between the adder stage and the result sink.
// PARAMETERS
//  IN_WIDTH   5  width of signed input sample (matches adder sum width)
//  ACC_WIDTH  8  width of signed accumulator / out_data; must be >= IN_WIDTH
//  COUNT      4  samples per frame; must be >= 1
// PORTS
//  clk       in   1          rising-edge clock
//  reset     in   1          asynchronous, active-high reset
//  start     in   1          begin a frame; sampled only in IDLE
//  in_valid  in   1          in_data is valid this cycle
//  in_data   in   IN_WIDTH   signed sample (two's complement)
//  in_ready  out  1          block accepts a sample this cycle
//  out_valid out  1          out_data/out_sat hold a completed frame
//  out_ready in   1          sink accepts the frame this cycle
//  out_data  out  ACC_WIDTH  signed saturated frame total
//  out_sat   out  1          1 if any add in this frame saturated
//  busy      out  1          state != IDLE
// BEHAVIOUR
//  - Reset (async assert, any state): state=IDLE, acc=0, beat count=0, sat=0;
//    out_valid=0, out_data=0, out_sat=0, in_ready=0, busy=0. A partial frame is discarded.
//  - FSM IDLE -> ACCUM on start=1 (acc, count, sat cleared on that edge).
//    ACCUM -> DONE on the edge accepting the COUNT-th sample.
//    DONE -> IDLE on the edge where out_valid && out_ready.
//  - in_ready = (state==ACCUM), a combinational decode of the state register.
//    Accept = in_valid && in_ready; in_valid gaps are allowed and stall the count.
//  - Per accepted sample: sum = acc + sign_extend(in_data), computed at ACC_WIDTH+1 bits.
//    If sum > 2^(ACC_WIDTH-1)-1: acc = max, sat = 1. If sum < -2^(ACC_WIDTH-1): acc = min, sat = 1.
//    Otherwise acc = sum. Later samples continue from the clamped value. sat is sticky per frame.
//  - Latency: out_valid rises the cycle after the COUNT-th sample is accepted.
//    out_data = acc, out_sat = sat.
//  - DONE: out_valid=1; out_data/out_sat held stable until the handshake; in_ready=0.
//    out_valid drops the cycle after the handshake.
//  - start outside IDLE is ignored, including in the DONE-handshake cycle.
//    A frame needs start asserted while in IDLE.
//  - out_ready outside DONE is ignored.
//  - out_data keeps the last frame value while IDLE and ACCUM; only out_valid qualifies it.
// TESTING
//  1 reset mid-frame: start, accept 7,7, assert reset -> out_valid=0, busy=0, out_data=0 at once;
//    new frame 1,1,1,1 -> 4.
//  2 defaults: start; in 15,15,15,15 back-to-back -> out_valid next cycle, out_data=60, out_sat=0.
//    Then -16 x4 -> out_data=-64, out_sat=0.
//  3 ACC_WIDTH=6: in 15,15,15,15 -> out_data=31, out_sat=1.
//    Next frame -16,-16,-16,15 -> out_data=-17, out_sat=1 (clamped at -32).
//  4 in_valid gaps (1 on/2 off) with samples 3,-5,2,-1 -> out_data=-1 after the 4th accepted sample.
//    in_ready=1 throughout ACCUM.
//  5 backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_sat stable,
//    in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
//  6 start pulsed during ACCUM and in the handshake cycle -> no effect.
//    Block idles until the next start.
//  Bench: self-checking golden model (clamped sum), error/correct counters, drive on negedge.

Source files
------------

// File: rtl/signed_sum_accumulator.sv
// Frame accumulator for signed adder samples: sums COUNT samples into a saturating
// total, flags any clipping, and hands the frame to the sink over valid/ready.
module signed_sum_accumulator #(
    parameter int unsigned IN_WIDTH  = 5,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;
    logic                 sat_d;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic                 out_sat_q;

    logic [SUM_W-1:0]     in_ext;
    logic [SUM_W-1:0]     acc_ext;
    logic [SUM_W-1:0]     sum;
    logic                 ovf;
    logic                 accept;
    logic                 last_beat;

    // One guard bit above the accumulator exposes overflow as a mismatch of the top two bits.
    always_comb begin
        in_ext  = {{(SUM_W - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
        sum     = acc_ext + in_ext;
        ovf     = sum[SUM_W-1] ^ sum[SUM_W-2];
        acc_d   = sum[ACC_WIDTH-1:0];
        if (ovf) begin
            acc_d = sum[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        sat_d = sat_q | ovf;
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(COUNT - 1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        if (last_beat) begin
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= acc_d;
                            out_sat_q   <= sat_d;
                            state_q     <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Result stays frozen until the sink takes it.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
